// File: rtl/mem_pkg.sv
// Shared types and defaults for the main memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 32;
  localparam int DEF_LATENCY = 4;
  localparam int CTR_W       = 4;

endpackage

// File: rtl/mem_wait_ctr.sv
// Down-counter that paces the WAIT phase of the main memory controller.
module mem_wait_ctr
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CTR_W-1:0] loadVal_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CTR_W-1:0] count_q;

  // Saturates at zero so a stray decrement can never wrap around.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadVal_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency single-request main memory controller.
// Optional even-parity per word when MAIN_MEM_PARITY_EN is defined.
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MStrobe,
  input  logic          MRW,
  input  logic [AW-1:0] MAddr,
  input  logic [DW-1:0] MDataIn,
  output logic [DW-1:0] MDataOut,
  output logic          MRdy,
  output logic          MBusy,
  output logic          PErr
);

`ifdef MAIN_MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  state_t        state_q, state_d;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] dataOut_q;
  logic [MW-1:0] memArray_q [2**AW];

  logic          ctrLoad;
  logic          ctrDec;
  logic          ctrZero;
  logic          memWrEn;
  logic [MW-1:0] wordIn;
  logic [MW-1:0] wordRd;

  mem_wait_ctr u_wait_ctr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ctrLoad),
    .loadVal_i (CTR_W'(LATENCY - 1)),
    .dec_i     (ctrDec),
    .zero_o    (ctrZero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrLoad = 1'b0;
    ctrDec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MStrobe) begin
          ctrLoad = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        ctrDec = 1'b1;
        if (ctrZero) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; later bus activity is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (ctrLoad) begin
      rw_q    <= MRW;
      addr_q  <= MAddr;
      wdata_q <= MDataIn;
    end
  end

  assign wordRd = memArray_q[addr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut_q <= '0;
    end else if ((state_q == ACCESS) && !rw_q) begin
      dataOut_q <= wordRd[DW-1:0];
    end
  end

  // The array has no reset; a reset in the ACCESS cycle must still block the write.
  assign memWrEn = (state_q == ACCESS) && rw_q && !reset;

  always_ff @(posedge clk) begin
    if (memWrEn) begin
      memArray_q[addr_q] <= wordIn;
    end
  end

`ifdef MAIN_MEM_PARITY_EN
  logic perr_q;

  assign wordIn = {^wdata_q, wdata_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      perr_q <= !rw_q && (^wordRd);
    end
  end

  assign PErr = (state_q == DONE) && perr_q;
`else
  assign wordIn = wdata_q;
  assign PErr   = 1'b0;
`endif

  assign MDataOut = dataOut_q;
  assign MRdy     = (state_q == DONE);
  assign MBusy    = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl (LATENCY 4, plus 1 and 15 instances for latency bounds).
module tb_main_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MStrobe;
  logic        MRW;
  logic [7:0]  MAddr;
  logic [31:0] MDataIn;

  logic [31:0] dout4, dout1, dout15;
  logic        rdy4, rdy1, rdy15;
  logic        busy4, busy1, busy15;
  logic        perr4, perr1, perr15;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word array plus the expected held read data.
  logic [31:0] refMem [256];
  logic [31:0] refDout;

  logic [31:0] rdyMask4, busyMask4, rdyMask1, rdyMask15;
  logic [31:0] doutSeen;
  logic        perrSeen;

  always #5 clk = ~clk;

  main_mem_ctrl #(.AW(8), .DW(32), .LATENCY(4)) dut (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(dout4), .MRdy(rdy4), .MBusy(busy4), .PErr(perr4)
  );

  main_mem_ctrl #(.AW(8), .DW(32), .LATENCY(1)) dutL1 (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(dout1), .MRdy(rdy1), .MBusy(busy1), .PErr(perr1)
  );

  main_mem_ctrl #(.AW(8), .DW(32), .LATENCY(15)) dutL15 (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(dout15), .MRdy(rdy15), .MBusy(busy15), .PErr(perr15)
  );

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] expDout;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One request from idle; records per-cycle MRdy/MBusy relative to the accepting edge.
  task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [31:0] data);
    MStrobe = 1'b1;
    MRW     = rw;
    MAddr   = addr;
    MDataIn = data;
    @(posedge clk);
    #1;
    MStrobe = 1'b0;
    MRW     = 1'($urandom);
    MAddr   = 8'($urandom);
    MDataIn = $urandom;
    rdyMask4  = '0;
    busyMask4 = '0;
    rdyMask1  = '0;
    rdyMask15 = '0;
    doutSeen  = 32'hxxxx_xxxx;
    perrSeen  = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy4) begin
        rdyMask4[n] = 1'b1;
        doutSeen    = dout4;
        perrSeen    = perr4;
      end
      if (busy4)  busyMask4[n] = 1'b1;
      if (rdy1)   rdyMask1[n]  = 1'b1;
      if (rdy15)  rdyMask15[n] = 1'b1;
    end
  endtask

  // Runs a request against dut and checks timing and data against the model.
  task automatic modelRequest(input string tag, input logic rw, input logic [7:0] addr,
                              input logic [31:0] data);
    applyStimulus(rw, addr, data);
    if (rw) refMem[addr] = data;
    else    refDout = refMem[addr];
    checkOutput({tag, " rdy"}, 64'(rdyMask4), 64'(32'h1 << 6));
    checkOutput({tag, " dout"}, 64'(doutSeen), 64'(refDout));
    checkOutput({tag, " perr"}, 64'(perrSeen), 64'd0);
  endtask

  vec_t table_v [11];
  int   rdyCount;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    table_v[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
    table_v[1]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    table_v[2]  = '{1'b1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF};
    table_v[3]  = '{1'b1, 8'hFF, 32'hA5A5A5A5, 32'hDEADBEEF};
    table_v[4]  = '{1'b0, 8'hFF, 32'h0,        32'hA5A5A5A5};
    table_v[5]  = '{1'b1, 8'h00, 32'h00000001, 32'hA5A5A5A5};
    table_v[6]  = '{1'b0, 8'h00, 32'h0,        32'h00000001};
    table_v[7]  = '{1'b0, 8'h20, 32'h0,        32'hCAFEF00D};
    table_v[8]  = '{1'b1, 8'h10, 32'hFFFFFFFF, 32'hCAFEF00D};
    table_v[9]  = '{1'b0, 8'h10, 32'h0,        32'hFFFFFFFF};
    table_v[10] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'hFFFFFFFF};

    reset   = 1'b1;
    MStrobe = 1'b0;
    MRW     = 1'b0;
    MAddr   = '0;
    MDataIn = '0;
    refDout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rdy",  64'(rdy4),  64'd0);
    checkOutput("reset busy", 64'(busy4), 64'd0);
    checkOutput("reset perr", 64'(perr4), 64'd0);
    checkOutput("reset dout", 64'(dout4), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(table_v[i].rw, table_v[i].addr, table_v[i].data);
      if (table_v[i].rw) refMem[table_v[i].addr] = table_v[i].data;
      else               refDout = refMem[table_v[i].addr];
      checkOutput($sformatf("vec%0d rdy", i),   64'(rdyMask4),  64'(32'h1 << 6));
      checkOutput($sformatf("vec%0d busy", i),  64'(busyMask4), 64'(32'h7E));
      checkOutput($sformatf("vec%0d dout", i),  64'(doutSeen),  64'(table_v[i].expDout));
      checkOutput($sformatf("vec%0d perr", i),  64'(perrSeen),  64'd0);
      checkOutput($sformatf("vec%0d lat1", i),  64'(rdyMask1),  64'(32'h1 << 3));
      checkOutput($sformatf("vec%0d lat15", i), 64'(rdyMask15), 64'(32'h1 << 17));
    end

    // Back-to-back strobes: one MRdy every LATENCY+3 cycles, one idle cycle between.
    begin
      logic [31:0] rdyPat, busyPat, rdyExp, busyExp;
      rdyPat  = '0;
      busyPat = '0;
      rdyExp  = '0;
      busyExp = '0;
      MStrobe = 1'b1;
      MRW     = 1'b0;
      MAddr   = 8'h10;
      for (int n = 1; n <= 28; n++) begin
        @(negedge clk);
        rdyPat[n]  = rdy4;
        busyPat[n] = busy4;
        rdyExp[n]  = (n % 7 == 6);
        busyExp[n] = (n % 7 != 0);
      end
      MStrobe = 1'b0;
      repeat (20) @(negedge clk);
      refDout = refMem[8'h10];
      checkOutput("busy strobe rdy",  64'(rdyPat),  64'(rdyExp));
      checkOutput("busy strobe busy", 64'(busyPat), 64'(busyExp));
      checkOutput("busy strobe dout", 64'(dout4),   64'(refDout));
    end

    // Reset while the write sits in WAIT.
    MStrobe = 1'b1;
    MRW     = 1'b1;
    MAddr   = 8'h20;
    MDataIn = 32'h12345678;
    @(posedge clk);
    #1;
    MStrobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortW rdy",  64'(rdy4),  64'd0);
    checkOutput("abortW busy", 64'(busy4), 64'd0);
    checkOutput("abortW perr", 64'(perr4), 64'd0);
    checkOutput("abortW dout", 64'(dout4), 64'd0);
    reset    = 1'b0;
    refDout  = '0;
    rdyCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy4) rdyCount++;
    end
    checkOutput("abortW no rdy", 64'(rdyCount), 64'd0);
    modelRequest("abortW readback", 1'b0, 8'h20, 32'h0);

    // Reset exactly in the ACCESS cycle of a write.
    MStrobe = 1'b1;
    MRW     = 1'b1;
    MAddr   = 8'h20;
    MDataIn = 32'h11111111;
    @(posedge clk);
    #1;
    MStrobe = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortA rdy",  64'(rdy4),  64'd0);
    checkOutput("abortA busy", 64'(busy4), 64'd0);
    reset    = 1'b0;
    refDout  = '0;
    rdyCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy4) rdyCount++;
    end
    checkOutput("abortA no rdy", 64'(rdyCount), 64'd0);
    modelRequest("abortA readback", 1'b0, 8'h20, 32'h0);

    // Parity corruption on a stored word.
    modelRequest("par write", 1'b1, 8'h30, 32'h0F0F0F0F);
`ifdef MAIN_MEM_PARITY_EN
    dut.memArray_q[8'h30][32] = ~dut.memArray_q[8'h30][32];
`endif
    applyStimulus(1'b0, 8'h30, 32'h0);
    refDout = refMem[8'h30];
    checkOutput("par rdy",  64'(rdyMask4), 64'(32'h1 << 6));
    checkOutput("par dout", 64'(doutSeen), 64'(refDout));
`ifdef MAIN_MEM_PARITY_EN
    checkOutput("par perr", 64'(perrSeen), 64'd1);
`else
    checkOutput("par perr", 64'(perrSeen), 64'd0);
`endif

    // Randomised traffic over a small, pre-initialised window.
    for (int a = 8'h40; a < 8'h50; a++) begin
      modelRequest("rnd init", 1'b1, 8'(a), $urandom);
    end
    for (int k = 0; k < 30; k++) begin
      modelRequest($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                   8'(8'h40 + $urandom_range(0, 15)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
